// File: rtl/procesador_fifo_resultados_csr.sv
// procesador_fifo_resultados_csr: Avalon-ST result capture FIFO read through an Avalon-MM CSR slave
module procesador_fifo_resultados_csr #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 13,
    parameter int THRESH_RESET = 2 ** (DEPTH_LOG2 - 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] avalonst_sink_data,
    input  logic                  avalonst_sink_valid,
    output logic                  avalonst_sink_ready,
    input  logic [2:0]            avalonmm_read_slave_address,
    input  logic                  avalonmm_read_slave_read,
    input  logic                  avalonmm_read_slave_write,
    input  logic [31:0]           avalonmm_read_slave_writedata,
    output logic [31:0]           avalonmm_read_slave_readdata,
    output logic                  irq
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d, thresh_q, thresh_d;
    logic [31:0]           csr_q, csr_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d, irq_en_q, irq_en_d, irq_q, irq_d, sel_ram_q, sel_ram_d;
    logic                  full, empty, at_thr, push, pop, rd0, ctl_wr, thr_wr, flush, clr;
    logic [5:0]            status;
    logic                  unused;

    assign unused = ^avalonmm_read_slave_writedata;

    always_comb begin
        full      = level_q == LW'(DEPTH);
        empty     = level_q == '0;
        at_thr    = level_q >= thresh_q;
        rd0       = avalonmm_read_slave_read && avalonmm_read_slave_address == 3'd0;
        ctl_wr    = avalonmm_read_slave_write && avalonmm_read_slave_address == 3'd2;
        thr_wr    = avalonmm_read_slave_write && avalonmm_read_slave_address == 3'd3;
        flush     = ctl_wr & avalonmm_read_slave_writedata[0];
        clr       = ctl_wr & avalonmm_read_slave_writedata[1];
        push      = avalonst_sink_valid & ~full & ~flush;
        pop       = rd0 & ~empty;
        status    = {irq_en_q, at_thr, udf_q, ovf_q, full, empty};
        wr_ptr_d  = flush ? '0 : wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d  = flush ? '0 : rd_ptr_q + DEPTH_LOG2'(pop);
        level_d   = flush ? '0 : level_q + LW'(push) - LW'(pop);
        ovf_d     = (avalonst_sink_valid & full & ~flush) | (ovf_q & ~clr);
        udf_d     = (rd0 & empty) | (udf_q & ~clr);
        irq_en_d  = ctl_wr ? avalonmm_read_slave_writedata[2] : irq_en_q;
        thresh_d  = thr_wr ? avalonmm_read_slave_writedata[LW-1:0] : thresh_q;
        irq_d     = irq_en_q & (at_thr | ovf_q);
        sel_ram_d = avalonmm_read_slave_read ? pop : sel_ram_q;
        csr_d     = !avalonmm_read_slave_read ? csr_q :
                    avalonmm_read_slave_address == 3'd1 ? 32'(level_q) :
                    avalonmm_read_slave_address == 3'd2 ? 32'(status) :
                    avalonmm_read_slave_address == 3'd3 ? 32'(thresh_q) : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            thresh_q  <= LW'(THRESH_RESET);
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            sel_ram_q <= 1'b0;
            csr_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            thresh_q  <= thresh_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            sel_ram_q <= sel_ram_d;
            csr_q     <= csr_d;
        end
    end

    // RAM and its output register stay unreset so the array maps onto block RAM
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= avalonst_sink_data;
        if (pop) ram_q <= mem[rd_ptr_q];
    end

    assign avalonst_sink_ready          = ~full;
    assign avalonmm_read_slave_readdata = sel_ram_q ? 32'(ram_q) : csr_q;
    assign irq                          = irq_q;
endmodule
